// File: rtl/game_pkg.sv
// Shared constants for the player-movement path: screen geometry, default
// debounce length and the 2-bit move-direction encoding.
package game_pkg;

    localparam int MONITOR_WIDTH           = 640;
    localparam int PLAYER_WIDTH            = 24;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 250000;

    typedef logic [1:0] dir_t;

    localparam dir_t DIR_NONE  = 2'b00;
    localparam dir_t DIR_LEFT  = 2'b01;
    localparam dir_t DIR_RIGHT = 2'b10;

    // Single-button cases are fixed; the both-held outcome is supplied by the caller.
    function automatic dir_t resolve_dir(input logic db_left,
                                         input logic db_right,
                                         input dir_t both_dir);
        dir_t dir;
        dir = DIR_NONE;
        if (db_left && !db_right) begin
            dir = DIR_LEFT;
        end else if (!db_left && db_right) begin
            dir = DIR_RIGHT;
        end else if (db_left && db_right) begin
            dir = both_dir;
        end
        return dir;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button conditioner: two-flop synchroniser followed by a
// persistence counter that only accepts a level held DEBOUNCE_CYCLES clocks.
module btn_debounce
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = 18
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_Raw,
    output logic o_Db
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync_meta;
    logic             r_sync;
    logic [CNT_W-1:0] r_cnt;
    logic             r_db;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_db_next;

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            r_sync_meta <= 1'b0;
            r_sync      <= 1'b0;
        end else begin
            r_sync_meta <= i_Raw;
            r_sync      <= r_sync_meta;
        end
    end

    // Any cycle where the synced level agrees with the accepted level restarts the count.
    always_comb begin
        w_cnt_next = '0;
        w_db_next  = r_db;
        if (r_sync != r_db) begin
            if (r_cnt == CNT_LAST) begin
                w_db_next  = r_sync;
                w_cnt_next = '0;
            end else begin
                w_cnt_next = r_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            r_cnt <= '0;
            r_db  <= 1'b0;
        end else begin
            r_cnt <= w_cnt_next;
            r_db  <= w_db_next;
        end
    end

    assign o_Db = r_db;

endmodule

// File: rtl/btn_move_ctrl.sv
// Left/right button front end: debounce both buttons, resolve conflicts and
// latch the move request on the frame tick. Option: BTN_LAST_PRESS_PRIORITY_EN.
module btn_move_ctrl
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = 18
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_Btn_Left_Raw,
    input  logic i_Btn_Right_Raw,
    input  logic i_fTick,
    output logic o_Btn_Left,
    output logic o_Btn_Right,
    output logic o_Btn_Left_Db,
    output logic o_Btn_Right_Db
);

    logic [1:0] w_raw;
    logic [1:0] w_db;
    dir_t       w_both_dir;
    dir_t       w_dir;
    logic       r_btn_left;
    logic       r_btn_right;

    // Bit 0 is left, bit 1 is right throughout.
    assign w_raw = {i_Btn_Right_Raw, i_Btn_Left_Raw};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_btn
            btn_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .CNT_W           (CNT_W)
            ) u_debounce (
                .i_Clk (i_Clk),
                .i_Rst (i_Rst),
                .i_Raw (w_raw[gi]),
                .o_Db  (w_db[gi])
            );
        end
    endgenerate

`ifdef BTN_LAST_PRESS_PRIORITY_EN
    logic [1:0] r_db_prev;
    logic       r_last_left;
    logic       w_rise_left;
    logic       w_rise_right;
    logic       w_last_left;

    assign w_rise_left  = w_db[0] & ~r_db_prev[0];
    assign w_rise_right = w_db[1] & ~r_db_prev[1];

    // Use the updated flag in the rising cycle itself; a simultaneous rise goes to left.
    always_comb begin
        w_last_left = r_last_left;
        if (w_rise_left) begin
            w_last_left = 1'b1;
        end else if (w_rise_right) begin
            w_last_left = 1'b0;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            r_db_prev   <= 2'b00;
            r_last_left <= 1'b0;
        end else begin
            r_db_prev   <= w_db;
            r_last_left <= w_last_left;
        end
    end

    assign w_both_dir = w_last_left ? DIR_LEFT : DIR_RIGHT;
`else
    assign w_both_dir = DIR_NONE;
`endif

    assign w_dir = resolve_dir(w_db[0], w_db[1], w_both_dir);

    // Requests change only at the end of a tick cycle so they are stable for a whole frame.
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            r_btn_left  <= 1'b0;
            r_btn_right <= 1'b0;
        end else if (i_fTick) begin
            r_btn_left  <= (w_dir == DIR_LEFT);
            r_btn_right <= (w_dir == DIR_RIGHT);
        end
    end

    assign o_Btn_Left     = r_btn_left;
    assign o_Btn_Right    = r_btn_right;
    assign o_Btn_Left_Db  = w_db[0];
    assign o_Btn_Right_Db = w_db[1];

endmodule

// File: tb/tb_btn_move_ctrl.sv
// Directed bench for btn_move_ctrl with DEBOUNCE_CYCLES=4 and a frame tick
// every 20 clocks; inputs change on the falling edge, outputs checked there too.
module tb_btn_move_ctrl;

    logic i_Clk = 1'b0;
    logic i_Rst = 1'b1;
    logic i_Btn_Left_Raw = 1'b0;
    logic i_Btn_Right_Raw = 1'b0;
    logic i_fTick = 1'b0;
    logic o_Btn_Left;
    logic o_Btn_Right;
    logic o_Btn_Left_Db;
    logic o_Btn_Right_Db;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    btn_move_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (3)
    ) dut (
        .i_Clk           (i_Clk),
        .i_Rst           (i_Rst),
        .i_Btn_Left_Raw  (i_Btn_Left_Raw),
        .i_Btn_Right_Raw (i_Btn_Right_Raw),
        .i_fTick         (i_fTick),
        .o_Btn_Left      (o_Btn_Left),
        .o_Btn_Right     (o_Btn_Right),
        .o_Btn_Left_Db   (o_Btn_Left_Db),
        .o_Btn_Right_Db  (o_Btn_Right_Db)
    );

    always #5 i_Clk = ~i_Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Advance n clocks; tick is driven high for the edge ending every 20th cycle.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge i_Clk);
            cyc++;
            i_fTick = ((cyc % 20) == 0);
            check("never_both", {31'd0, o_Btn_Left & o_Btn_Right}, 32'd0);
        end
    endtask

    // Stop just before a tick edge: outputs still show the previous frame.
    task automatic to_tick();
        int k;
        k = 0;
        while (!i_fTick && k < 21) begin
            step(1);
            k++;
        end
        check("tick_found", {31'd0, i_fTick}, 32'd1);
    endtask

    task automatic check_req(input string tag, input logic l, input logic r);
        check({tag, "_left"}, {31'd0, o_Btn_Left}, {31'd0, l});
        check({tag, "_right"}, {31'd0, o_Btn_Right}, {31'd0, r});
    endtask

    initial begin
        // 1: reset held with raw buttons toggling
        #2 i_Rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            i_Btn_Left_Raw  = k[0];
            i_Btn_Right_Raw = ~k[0];
            step(1);
        end
        check_req("rst_hold", 1'b0, 1'b0);
        check("rst_hold_ldb", {31'd0, o_Btn_Left_Db}, 32'd0);
        check("rst_hold_rdb", {31'd0, o_Btn_Right_Db}, 32'd0);
        i_Btn_Left_Raw  = 1'b0;
        i_Btn_Right_Raw = 1'b0;
        step(1);
        i_Rst = 1'b1;
        for (int t = 0; t < 3; t++) begin
            to_tick();
            step(1);
            check_req("idle_tick", 1'b0, 1'b0);
        end

        // 2: left press, 6-clock latency to debounced level, request from next tick
        i_Btn_Left_Raw = 1'b1;
        step(5);
        check("l_db_early", {31'd0, o_Btn_Left_Db}, 32'd0);
        step(1);
        check("l_db_rise", {31'd0, o_Btn_Left_Db}, 32'd1);
        to_tick();
        check_req("l_in_tick", 1'b0, 1'b0);
        step(1);
        check_req("l_after_tick", 1'b1, 1'b0);
        to_tick();
        step(1);
        check_req("l_hold", 1'b1, 1'b0);
        i_Btn_Left_Raw = 1'b0;
        step(5);
        check("l_db_rel_early", {31'd0, o_Btn_Left_Db}, 32'd1);
        step(1);
        check("l_db_fall", {31'd0, o_Btn_Left_Db}, 32'd0);
        to_tick();
        check_req("l_rel_in_tick", 1'b1, 1'b0);
        step(1);
        check_req("l_rel_after", 1'b0, 1'b0);

        // 3: 3-high/1-low glitches on right must be rejected
        for (int k = 0; k < 50; k++) begin
            i_Btn_Right_Raw = ((k % 4) != 3);
            step(1);
            check("glitch_rdb", {31'd0, o_Btn_Right_Db}, 32'd0);
            check("glitch_rreq", {31'd0, o_Btn_Right}, 32'd0);
        end
        i_Btn_Right_Raw = 1'b0;
        step(8);
        check("glitch_rdb_end", {31'd0, o_Btn_Right_Db}, 32'd0);

        // 4: both held
        i_Btn_Left_Raw = 1'b1;
        step(6);
        to_tick();
        step(1);
        check_req("both_l_only", 1'b1, 1'b0);
        i_Btn_Right_Raw = 1'b1;
        step(6);
        check("both_rdb", {31'd0, o_Btn_Right_Db}, 32'd1);
        to_tick();
        step(1);
`ifdef BTN_LAST_PRESS_PRIORITY_EN
        check_req("both_held", 1'b0, 1'b1);
`else
        check_req("both_held", 1'b0, 1'b0);
`endif
        i_Btn_Right_Raw = 1'b0;
        step(6);
        to_tick();
        step(1);
        check_req("both_r_rel", 1'b1, 1'b0);
        i_Btn_Left_Raw = 1'b0;
        step(6);
        to_tick();
        step(1);
        check_req("both_all_rel", 1'b0, 1'b0);

        // 5: press accepted 5 clocks after a tick, released 10 clocks later
        to_tick();
        i_Btn_Left_Raw = 1'b1;
        step(6);
        check("short_db_on", {31'd0, o_Btn_Left_Db}, 32'd1);
        check("short_req0", {31'd0, o_Btn_Left}, 32'd0);
        step(4);
        i_Btn_Left_Raw = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step(1);
            check("short_req", {31'd0, o_Btn_Left}, 32'd0);
        end
        check("short_db_off", {31'd0, o_Btn_Left_Db}, 32'd0);
        step(6);
        check_req("short_after_tick", 1'b0, 1'b0);

        // 6: reset pulse mid-frame while left request is active
        i_Btn_Left_Raw = 1'b1;
        step(6);
        to_tick();
        step(1);
        check_req("rstp_before", 1'b1, 1'b0);
        step(3);
        i_Rst = 1'b0;
        #1;
        check("rstp_async_left", {31'd0, o_Btn_Left}, 32'd0);
        check("rstp_async_ldb", {31'd0, o_Btn_Left_Db}, 32'd0);
        step(1);
        i_Rst = 1'b1;
        step(5);
        check("rstp_db_early", {31'd0, o_Btn_Left_Db}, 32'd0);
        step(1);
        check("rstp_db_rise", {31'd0, o_Btn_Left_Db}, 32'd1);
        check_req("rstp_wait", 1'b0, 1'b0);
        to_tick();
        check_req("rstp_in_tick", 1'b0, 1'b0);
        step(1);
        check_req("rstp_after_tick", 1'b1, 1'b0);
        i_Btn_Left_Raw = 1'b0;
        step(3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/btn_move_ctrl.md
Name: btn_move_ctrl

Overview:
- Front end of the player-movement path: conditions the raw left/right push-buttons into clean, frame-aligned move requests.
- Its outputs drive the left/right button inputs of the player-position update logic.
- Synchronises and debounces each button, resolves simultaneous presses, and updates the requests only on the frame tick, so a request holds steady for a whole frame.

Parameters:
- DEBOUNCE_CYCLES, 250000: consecutive clocks a synchronised level must persist before it is accepted (10 ms at 25 MHz); legal range ≥ 2.
- CNT_W, 18: debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- i_Clk  input  1  system clock (pixel clock domain).
- i_Rst  input  1  reset, asynchronous, active-low.
- i_Btn_Left_Raw  input  1  raw left button, active-high, asynchronous to i_Clk.
- i_Btn_Right_Raw  input  1  raw right button, active-high, asynchronous to i_Clk.
- i_fTick  input  1  one-clock pulse, once per frame.
- o_Btn_Left  output  1  move-left request; held constant between frame ticks.
- o_Btn_Right  output  1  move-right request; held constant between frame ticks.
- o_Btn_Left_Db  output  1  debounced left level (status/LED use).
- o_Btn_Right_Db  output  1  debounced right level (status/LED use).

Behaviour:
- Reset (i_Rst=0, async):
  - Synchroniser flops, debounce counters, debounced levels, last-pressed flag and all outputs go to 0.
  - Release of reset is synchronous to i_Clk.
- Synchroniser: two-flop chain per raw button; no logic between the stages.
- Debounce, per button, with synced level s and accepted level d:
  - If s == d: counter clears to 0.
  - If s != d: counter increments.
  - When the counter equals DEBOUNCE_CYCLES-1 while s != d: d takes s on the next edge and the counter clears.
  - Any single-cycle return to s == d clears the counter, so glitches shorter than DEBOUNCE_CYCLES clocks are rejected.
  - Counter never wraps; it cannot exceed DEBOUNCE_CYCLES-1.
- Latency from raw edge to debounced-level change: 2 + DEBOUNCE_CYCLES clocks when the input is clean.
- Direction resolution (combinational, on the debounced levels dL and dR):
  - dL only: request left.
  - dR only: request right.
  - Neither: no request.
  - Both: see Optional Feature.
- Frame alignment:
  - o_Btn_Left and o_Btn_Right are registers loaded from the resolved request only in a cycle with i_fTick=1.
  - They update on the clock edge that ends the tick cycle and are otherwise held.
  - During the tick cycle itself the outputs still carry the previous frame's values, so the downstream position register samples stable data.
  - The two outputs are never 1 simultaneously.
- Press shorter than one frame: a press that is accepted and then released between two ticks produces no request (intended).
- Reset mid-frame: outputs drop to 0 immediately. The first request after reset appears at the first tick that follows debounce acceptance.
- o_Btn_*_Db outputs are the debounced levels directly; they are not tick-aligned.

Optional Feature:
- Macro: BTN_LAST_PRESS_PRIORITY_EN.
- Defined:
  - A registered last-pressed flag records which debounced level most recently rose from 0 to 1.
  - If both rise in the same cycle, left wins.
  - While both are held, the request follows the last-pressed button.
  - When one button is released, the request goes to the one still held.
- Not defined: both held gives no request, and no last-pressed register is built.

Decomposition:
- Shared package game_pkg holds:
  - MONITOR_WIDTH (640) and PLAYER_WIDTH (24);
  - the default DEBOUNCE_CYCLES;
  - direction encoding constants DIR_NONE=2'b00, DIR_LEFT=2'b01, DIR_RIGHT=2'b10. The resolver uses this 2-bit encoding internally.
- One natural sub-module, btn_debounce: one synchroniser plus counter plus accepted level. It is instantiated twice and takes DEBOUNCE_CYCLES and CNT_W as parameters.
- Resolution logic and the tick register stay in the top level.

Test Plan (DEBOUNCE_CYCLES=4, i_fTick every 20 clocks):
1. Reset held, raw buttons toggling -> all outputs 0. Release reset with buttons at 0 -> outputs remain 0 through 3 ticks.
2. Left raw rises and stays -> o_Btn_Left_Db rises 6 clocks later. o_Btn_Left rises the clock after the next tick and stays 1 until the tick after release is accepted.
3. Right raw pulses with 3-clock glitches separated by 1-clock lows for 50 clocks -> o_Btn_Right_Db and o_Btn_Right stay 0.
4. Left held, then right pressed while left is held:
   - without macro: request drops to 0 at the next tick;
   - with macro: o_Btn_Right=1, o_Btn_Left=0 at the next tick;
   - with macro, release right: o_Btn_Left returns to 1 at the following tick.
5. Left accepted 5 clocks after a tick and released (accepted) 10 clocks later, before the next tick -> o_Btn_Left never asserts.
6. Left request active; i_Rst pulsed low for 1 clock mid-frame -> o_Btn_Left falls asynchronously. It reasserts 6 clocks after reset release plus the next tick, and is never 1 together with o_Btn_Right.
